// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg
//   Shared definitions for the writeback stage: opcode/funct field widths,
//   the load opcodes the stage recognises, and a small load-size decoder.
//   No ports; imported by writeback_stage and load_extender.
package writeback_stage_pkg;

  localparam int OPCODE_WIDTH = 6;
  localparam int FUNCT_WIDTH  = 6;

  localparam logic [OPCODE_WIDTH-1:0] OP_LB  = 6'h20;
  localparam logic [OPCODE_WIDTH-1:0] OP_LH  = 6'h21;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW  = 6'h23;
  localparam logic [OPCODE_WIDTH-1:0] OP_LBU = 6'h24;
  localparam logic [OPCODE_WIDTH-1:0] OP_LHU = 6'h25;

  typedef enum logic [1:0] {
    LOAD_NONE = 2'd0,
    LOAD_BYTE = 2'd1,
    LOAD_HALF = 2'd2,
    LOAD_WORD = 2'd3
  } load_size_e;

  // Collapse the load opcodes into an access size; anything else is not a load
  function automatic load_size_e decode_load_size(input logic [OPCODE_WIDTH-1:0] opcode);
    load_size_e size;
    size = LOAD_NONE;
    if (opcode == OP_LB || opcode == OP_LBU) size = LOAD_BYTE;
    if (opcode == OP_LH || opcode == OP_LHU) size = LOAD_HALF;
    if (opcode == OP_LW)                     size = LOAD_WORD;
    return size;
  endfunction

  // Only LB and LH sign-extend; the U variants zero-extend
  function automatic logic is_signed_load(input logic [OPCODE_WIDTH-1:0] opcode);
    return (opcode == OP_LB) || (opcode == OP_LH);
  endfunction

endpackage

// File: rtl/writeback_stage_load_extender.sv
// load_extender
//   Combinational sub-word load extraction for the writeback stage.
//   Picks the byte or halfword lane addressed by the low address bits
//   (little-endian), sign- or zero-extends it, and flags misaligned
//   halfword/word loads. Non-load opcodes pass the word through.
//   Compiled only when WB_SUBWORD_LOAD_EN is defined.
// Ports:
//   opcode   in  OPCODE_WIDTH  opcode of the instruction being captured
//   off      in  2             byte offset, ALU result bits [1:0]
//   word     in  32            word read from data memory
//   data     out 32            extracted and extended load value
//   misalign out 1             halfword/word access not naturally aligned
`ifdef WB_SUBWORD_LOAD_EN
module load_extender
  import writeback_stage_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [1:0]              off,
  input  logic [31:0]             word,
  output logic [31:0]             data,
  output logic                    misalign
);

  load_size_e  size;
  logic        sign_ext;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane selection and extension; a halfword lane is chosen by off[1] alone,
  // so off[0] only matters for the misalignment flag.
  always_comb begin
    size      = decode_load_size(opcode);
    sign_ext  = is_signed_load(opcode);
    data      = word;
    misalign  = 1'b0;
    case (off)
      2'd0:    byte_lane = word[7:0];
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      default: byte_lane = word[31:24];
    endcase
    half_lane = off[1] ? word[31:16] : word[15:0];
    case (size)
      LOAD_BYTE: data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      LOAD_HALF: begin
        data     = {{16{sign_ext & half_lane[15]}}, half_lane};
        misalign = off[0];
      end
      LOAD_WORD: misalign = |off;
      default:   data = word;
    endcase
  end

endmodule
`endif

// File: rtl/writeback_stage.sv
// writeback_stage
//   Final MIPS pipeline stage. Registers the memory-stage result, selects ALU
//   value or load data, and drives the register-file write port. Also counts
//   committed instructions and reports misaligned loads.
//   Optional feature macro: WB_SUBWORD_LOAD_EN enables LB/LBU/LH/LHU/LW lane
//   extraction and misalignment detection; without it load data passes
//   through unchanged and wb_o_misalign stays 0.
// Ports:
//   wb_clk, wb_rst         clock (rising edge), async active-low reset
//   wb_i_ce/stall/flush    valid, hold, discard controls from upstream
//   wb_i_opcode            opcode carried down the pipe
//   wb_i_alu_value         ALU result; bits [1:0] are the load byte offset
//   wb_i_load_data         word read from data memory
//   wb_i_rd_addr           destination register
//   wb_i_reg_wr            RegWrite control
//   wb_i_memtoreg          1 = load data, 0 = ALU value
//   wb_o_data/rd_addr      register-file write data/address (held when idle)
//   wb_o_reg_wr            write strobe, one cycle per commit
//   wb_o_ce                instruction committed this cycle
//   wb_o_misalign          committed load was misaligned (write suppressed)
//   wb_o_retired           committed-instruction count, wraps
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 5,
  parameter int CNTWIDTH = 32
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  input  logic                    wb_i_ce,
  input  logic                    wb_i_stall,
  input  logic                    wb_i_flush,
  input  logic [OPCODE_WIDTH-1:0] wb_i_opcode,
  input  logic [DWIDTH-1:0]       wb_i_alu_value,
  input  logic [DWIDTH-1:0]       wb_i_load_data,
  input  logic [AWIDTH-1:0]       wb_i_rd_addr,
  input  logic                    wb_i_reg_wr,
  input  logic                    wb_i_memtoreg,
  output logic [DWIDTH-1:0]       wb_o_data,
  output logic [AWIDTH-1:0]       wb_o_rd_addr,
  output logic                    wb_o_reg_wr,
  output logic                    wb_o_ce,
  output logic                    wb_o_misalign,
  output logic [CNTWIDTH-1:0]     wb_o_retired
);

  logic              capture;
  logic [DWIDTH-1:0] load_value;
  logic [DWIDTH-1:0] next_data;
  logic              load_misalign;

`ifdef WB_SUBWORD_LOAD_EN
  load_extender u_load_extender (
    .opcode   (wb_i_opcode),
    .off      (wb_i_alu_value[1:0]),
    .word     (wb_i_load_data),
    .data     (load_value),
    .misalign (load_misalign)
  );
`else
  // Opcode is only needed for lane extraction; keep it visibly sunk
  logic unused_opcode;
  assign unused_opcode = ^wb_i_opcode;
  assign load_value    = wb_i_load_data;
  assign load_misalign = 1'b0;
`endif

  // Stall outranks flush, flush outranks ce
  assign capture   = wb_i_ce & ~wb_i_stall & ~wb_i_flush;
  assign next_data = wb_i_memtoreg ? load_value : wb_i_alu_value;

  // Stage register. Control outputs are recomputed every cycle so they drop
  // to 0 when nothing is captured; data/address hold their last values.
  // The counter advances at capture so it already reflects the commit in the
  // cycle wb_o_ce is high.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      wb_o_data     <= '0;
      wb_o_rd_addr  <= '0;
      wb_o_reg_wr   <= 1'b0;
      wb_o_ce       <= 1'b0;
      wb_o_misalign <= 1'b0;
      wb_o_retired  <= '0;
    end else begin
      wb_o_ce       <= capture;
      wb_o_misalign <= capture & load_misalign;
      wb_o_reg_wr   <= capture & wb_i_reg_wr & ~load_misalign & (wb_i_rd_addr != '0);
      if (capture) begin
        wb_o_data    <= next_data;
        wb_o_rd_addr <= wb_i_rd_addr;
        wb_o_retired <= wb_o_retired + CNTWIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage
//   Self-checking bench for writeback_stage. The retired counter is built
//   4 bits wide so wrap-around is reached quickly. Expected values come from
//   directed constants and from a reference model of the load rules.
module tb_writeback_stage;

  localparam int CNTW = 4;

  localparam logic [5:0] T_LB  = 6'h20;
  localparam logic [5:0] T_LH  = 6'h21;
  localparam logic [5:0] T_LW  = 6'h23;
  localparam logic [5:0] T_LBU = 6'h24;
  localparam logic [5:0] T_LHU = 6'h25;
  localparam logic [5:0] T_SW  = 6'h2B;
  localparam logic [5:0] T_RTY = 6'h00;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_ce = 1'b0, i_stall = 1'b0, i_flush = 1'b0;
  logic [5:0]      i_opcode = '0;
  logic [31:0]     i_alu = '0, i_load = '0;
  logic [4:0]      i_rd = '0;
  logic            i_reg_wr = 1'b0, i_memtoreg = 1'b0;
  logic [31:0]     o_data;
  logic [4:0]      o_rd;
  logic            o_reg_wr, o_ce, o_mis;
  logic [CNTW-1:0] o_ret;

  logic [31:0] exp_data;
  logic [4:0]  exp_rd;
  logic        exp_wr, exp_ce, exp_mis;
  int          exp_ret;

  int checks = 0;
  int failures = 0;

  writeback_stage #(.DWIDTH(32), .AWIDTH(5), .CNTWIDTH(CNTW)) dut (
    .wb_clk         (clk),
    .wb_rst         (rst_n),
    .wb_i_ce        (i_ce),
    .wb_i_stall     (i_stall),
    .wb_i_flush     (i_flush),
    .wb_i_opcode    (i_opcode),
    .wb_i_alu_value (i_alu),
    .wb_i_load_data (i_load),
    .wb_i_rd_addr   (i_rd),
    .wb_i_reg_wr    (i_reg_wr),
    .wb_i_memtoreg  (i_memtoreg),
    .wb_o_data      (o_data),
    .wb_o_rd_addr   (o_rd),
    .wb_o_reg_wr    (o_reg_wr),
    .wb_o_ce        (o_ce),
    .wb_o_misalign  (o_mis),
    .wb_o_retired   (o_ret)
  );

  always #5 clk = ~clk;

  // Reference rule for load data: returns {misalign, data}
  function automatic logic [32:0] model_load(input logic [5:0] op, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [31:0] d;
    logic        m;
    int unsigned b, h;
    d = w;
    m = 1'b0;
    b = (w >> (8 * int'(off))) % 256;
    h = (w >> (16 * (int'(off) / 2))) % 65536;
`ifdef WB_SUBWORD_LOAD_EN
    if (op == T_LB || op == T_LBU)
      d = (op == T_LB && b >= 128) ? 32'(b) - 32'd256 : 32'(b);
    if (op == T_LH || op == T_LHU) begin
      d = (op == T_LH && h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
      m = (int'(off) % 2) != 0;
    end
    if (op == T_LW) m = (off != 2'd0);
`else
    if (b > 255 || h > 65535 || op == 6'h3F) d = w;
`endif
    return {m, d};
  endfunction

  task automatic model_reset();
    exp_data = '0; exp_rd = '0; exp_wr = 1'b0; exp_ce = 1'b0; exp_mis = 1'b0; exp_ret = 0;
  endtask

  // One clock: the model consumes the inputs present at the edge, then
  // outputs are sampled 1ns later by the caller.
  task automatic cycle();
    logic [32:0] lr;
    @(posedge clk);
    if (i_ce && !i_stall && !i_flush) begin
      lr       = model_load(i_opcode, i_alu[1:0], i_load);
      exp_ce   = 1'b1;
      exp_mis  = lr[32];
      exp_data = i_memtoreg ? lr[31:0] : i_alu;
      exp_rd   = i_rd;
      exp_wr   = i_reg_wr && !lr[32] && (i_rd != 5'd0);
      exp_ret  = (exp_ret + 1) % 16;
    end else begin
      exp_ce  = 1'b0;
      exp_wr  = 1'b0;
      exp_mis = 1'b0;
    end
    #1;
  endtask

  task automatic drive_instr(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] load,
                             input logic [4:0] rd, input logic wr, input logic mtr);
    i_ce = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
    i_opcode = op; i_alu = alu; i_load = load; i_rd = rd; i_reg_wr = wr; i_memtoreg = mtr;
  endtask

  task automatic drive_idle();
    i_ce = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    #3;
    checks++;
    if ({o_data, o_rd, o_reg_wr, o_ce, o_mis, o_ret} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_state: got data=%h rd=%0d wr=%b ce=%b mis=%b ret=%0d, want all 0",
               o_data, o_rd, o_reg_wr, o_ce, o_mis, o_ret);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    checks++;
    if (o_ce !== 1'b0 || o_reg_wr !== 1'b0 || o_ret !== 4'd0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: got ce=%b wr=%b ret=%0d, want 0 0 0", o_ce, o_reg_wr, o_ret);
    end
  endtask

  task automatic test_rtype();
    drive_instr(T_RTY, 32'h0000_00AB, 32'hDEAD_BEEF, 5'd5, 1'b1, 1'b0);
    cycle();
    drive_idle();
    checks++;
    if (o_data !== 32'hAB || o_rd !== 5'd5 || o_reg_wr !== 1'b1 || o_ce !== 1'b1
        || o_mis !== 1'b0 || o_ret !== 4'd1) begin
      failures++;
      $display("[TB] FAIL rtype: got data=%h rd=%0d wr=%b ce=%b mis=%b ret=%0d, want 000000ab 5 1 1 0 1",
               o_data, o_rd, o_reg_wr, o_ce, o_mis, o_ret);
    end
  endtask

  task automatic test_rd_zero();
    drive_instr(T_RTY, 32'h0000_1234, 32'h0, 5'd0, 1'b1, 1'b0);
    cycle();
    drive_idle();
    checks++;
    if (o_ce !== 1'b1 || o_reg_wr !== 1'b0 || o_rd !== 5'd0 || o_data !== 32'h1234 || o_ret !== 4'd2) begin
      failures++;
      $display("[TB] FAIL rd_zero: got ce=%b wr=%b rd=%0d data=%h ret=%0d, want 1 0 0 00001234 2",
               o_ce, o_reg_wr, o_rd, o_data, o_ret);
    end
  endtask

  task automatic test_subword();
    logic [5:0]  ops   [5];
    logic [31:0] alus  [5];
    logic [31:0] loads [5];
    logic [31:0] want_d[5];
    logic        want_m[5];
    ops   = '{T_LB, T_LBU, T_LH, T_LW, T_LHU};
    alus  = '{32'h0000_1001, 32'h0000_1001, 32'h0000_2002, 32'h0000_3002, 32'h0000_4003};
    loads = '{32'h1234_8056, 32'h1234_8056, 32'h8001_0000, 32'hCAFE_F00D, 32'h8001_0000};
`ifdef WB_SUBWORD_LOAD_EN
    want_d = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'hCAFE_F00D, 32'h0000_8001};
    want_m = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    want_d = '{32'h1234_8056, 32'h1234_8056, 32'h8001_0000, 32'hCAFE_F00D, 32'h8001_0000};
    want_m = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int k = 0; k < 5; k++) begin
      drive_instr(ops[k], alus[k], loads[k], 5'd7 + 5'(k), 1'b1, 1'b1);
      cycle();
      checks++;
      if (o_data !== want_d[k] || o_mis !== want_m[k] || o_reg_wr !== !want_m[k]
          || o_ce !== 1'b1 || o_rd !== 5'd7 + 5'(k) || o_ret !== 4'(exp_ret)) begin
        failures++;
        $display("[TB] FAIL subword_%0d: got data=%h mis=%b wr=%b ce=%b rd=%0d ret=%0d, want %h %b %b 1 %0d %0d",
                 k, o_data, o_mis, o_reg_wr, o_ce, o_rd, o_ret, want_d[k], want_m[k], !want_m[k],
                 7 + k, exp_ret);
      end
    end
    drive_idle();
  endtask

  task automatic test_flush_stall();
    logic [31:0] held;
    int          ret_before;
    held = exp_data;
    ret_before = exp_ret;
    drive_instr(T_RTY, 32'h5555_0001, 32'h0, 5'd9, 1'b1, 1'b0);
    i_flush = 1'b1;
    cycle();
    checks++;
    if (o_ce !== 1'b0 || o_reg_wr !== 1'b0 || o_data !== held || o_ret !== 4'(ret_before)) begin
      failures++;
      $display("[TB] FAIL ce_with_flush: got ce=%b wr=%b data=%h ret=%0d, want 0 0 %h %0d",
               o_ce, o_reg_wr, o_data, o_ret, held, ret_before);
    end
    i_flush = 1'b0;
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (o_reg_wr !== 1'b0 || o_ce !== 1'b0 || o_data !== held || o_ret !== 4'(ret_before)) begin
        failures++;
        $display("[TB] FAIL stall_hold_%0d: got wr=%b ce=%b data=%h ret=%0d, want 0 0 %h %0d",
                 k, o_reg_wr, o_ce, o_data, o_ret, held, ret_before);
      end
    end
    i_stall = 1'b0;
    cycle();
    drive_idle();
    checks++;
    if (o_ce !== 1'b1 || o_reg_wr !== 1'b1 || o_data !== 32'h5555_0001 || o_rd !== 5'd9
        || o_ret !== 4'((ret_before + 1) % 16)) begin
      failures++;
      $display("[TB] FAIL stall_release: got ce=%b wr=%b data=%h rd=%0d ret=%0d, want 1 1 55550001 9 %0d",
               o_ce, o_reg_wr, o_data, o_rd, o_ret, (ret_before + 1) % 16);
    end
    cycle();
    checks++;
    if (o_ce !== 1'b0 || o_reg_wr !== 1'b0 || o_ret !== 4'((ret_before + 1) % 16)) begin
      failures++;
      $display("[TB] FAIL single_commit: got ce=%b wr=%b ret=%0d, want 0 0 %0d",
               o_ce, o_reg_wr, o_ret, (ret_before + 1) % 16);
    end
  endtask

  task automatic test_async_reset();
    drive_instr(T_RTY, 32'h0BAD_F00D, 32'h0, 5'd3, 1'b1, 1'b0);
    cycle();
    drive_idle();
    checks++;
    if (o_ce !== 1'b1 || o_reg_wr !== 1'b1 || o_data !== 32'h0BAD_F00D) begin
      failures++;
      $display("[TB] FAIL pre_reset_commit: got ce=%b wr=%b data=%h, want 1 1 0badf00d", o_ce, o_reg_wr, o_data);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({o_data, o_rd, o_reg_wr, o_ce, o_mis, o_ret} !== '0) begin
      failures++;
      $display("[TB] FAIL async_reset: got data=%h rd=%0d wr=%b ce=%b mis=%b ret=%0d, want all 0",
               o_data, o_rd, o_reg_wr, o_ce, o_mis, o_ret);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      checks++;
      if (o_reg_wr !== 1'b0 || o_ce !== 1'b0 || o_ret !== 4'd0 || o_data !== 32'h0) begin
        failures++;
        $display("[TB] FAIL post_reset_%0d: got wr=%b ce=%b ret=%0d data=%h, want 0 0 0 0",
                 k, o_reg_wr, o_ce, o_ret, o_data);
      end
    end
  endtask

  task automatic test_wrap();
    for (int k = 1; k <= 17; k++) begin
      drive_instr(T_RTY, $urandom, 32'h0, 5'($urandom_range(1, 31)), 1'b1, 1'b0);
      cycle();
      checks++;
      if (o_ret !== 4'(k % 16) || o_ce !== 1'b1) begin
        failures++;
        $display("[TB] FAIL wrap_%0d: got ret=%0d ce=%b, want %0d 1", k, o_ret, o_ce, k % 16);
      end
    end
    drive_idle();
  endtask

  task automatic test_random();
    logic [5:0] pool[7];
    int         bad;
    pool = '{T_LB, T_LH, T_LW, T_LBU, T_LHU, T_SW, T_RTY};
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      i_ce       = ($urandom_range(0, 9) < 8);
      i_stall    = ($urandom_range(0, 9) < 2);
      i_flush    = ($urandom_range(0, 9) < 1);
      i_opcode   = pool[$urandom_range(0, 6)];
      i_alu      = $urandom;
      i_load     = $urandom;
      i_rd       = 5'($urandom_range(0, 31));
      i_reg_wr   = ($urandom_range(0, 3) != 0);
      i_memtoreg = 1'($urandom_range(0, 1));
      cycle();
      checks++;
      if (o_data !== exp_data || o_rd !== exp_rd || o_reg_wr !== exp_wr || o_ce !== exp_ce
          || o_mis !== exp_mis || o_ret !== 4'(exp_ret)) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("[TB] FAIL random_%0d: got data=%h rd=%0d wr=%b ce=%b mis=%b ret=%0d, want %h %0d %b %b %b %0d",
                   k, o_data, o_rd, o_reg_wr, o_ce, o_mis, o_ret,
                   exp_data, exp_rd, exp_wr, exp_ce, exp_mis, exp_ret);
      end
    end
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_rtype();
    test_rd_zero();
    test_subword();
    test_flush_stall();
    test_async_reset();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
